pdp_mem_arbiter: RTL and testbench
==================================

Name: pdp_mem_arbiter

Overview:
Shares the single PDP-8 main-memory port between the Instruction Fetch/Decode unit (IFD, read-only) and the Execute unit (EXE, read/write).
- One memory transaction in flight at a time.
- EXE has fixed priority; a starvation counter guarantees IFD progress.
- Sits between both units and the synchronous memory model; each unit sees a simple req/ack handshake.

Parameters:
MEM_RD_LAT, 1, cycles from mem_en sampled to mem_rdata valid (1..7)
STARVE_LIMIT, 4, consecutive EXE grants allowed while ifd_req pending before IFD is forced (1..15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ifd_req  in  1  IFD read request, held until ifd_ack
ifd_addr  in  `ADDR_WIDTH  IFD read address
ifd_ack  out  1  one-cycle pulse: IFD read complete
ifd_rdata  out  `DATA_WIDTH  IFD read data, valid in ack cycle, held until next IFD ack
exe_req  in  1  EXE request, held until exe_ack
exe_we  in  1  1 = write, 0 = read
exe_addr  in  `ADDR_WIDTH  EXE address
exe_wdata  in  `DATA_WIDTH  EXE write data
exe_ack  out  1  one-cycle pulse: EXE transaction complete
exe_rdata  out  `DATA_WIDTH  EXE read data, valid in ack cycle, held until next EXE read ack
mem_en  out  1  memory access strobe, one cycle per transaction
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  `ADDR_WIDTH  memory address
mem_wdata  out  `DATA_WIDTH  memory write data
mem_rdata  in  `DATA_WIDTH  memory read data
owner  out  2  current owner: 0 none, 1 IFD, 2 EXE

Behaviour:
- Reset values: all outputs 0; state IDLE; starvation counter 0; rdata registers 0.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: samples requests.
  - No request: stay in IDLE.
  - Otherwise select a winner and latch its addr/we/wdata, then go to ISSUE.
  - owner is updated on that same transition.
- Winner selection in IDLE:
  - Only one requester: that requester wins.
  - Both requesting: EXE wins, unless starve_cnt == STARVE_LIMIT, in which case IFD wins.
- ISSUE: one cycle.
  - mem_en=1; mem_we from latched we (always 0 for IFD); mem_addr and mem_wdata driven from latches.
  - Write: go to ACK.
  - Read: go to WAIT.
- WAIT: lasts exactly MEM_RD_LAT cycles.
  - mem_rdata is captured into the owner's rdata register on the last WAIT cycle.
  - Then go to ACK.
- ACK: one cycle.
  - Owner's ack=1.
  - Then go to IDLE with owner=0.
- Latency, counted from the IDLE cycle that sees the request:
  - Read: ack in cycle 2+MEM_RD_LAT.
  - Write: ack in cycle 2.
  - A new request is accepted no earlier than the IDLE cycle after ACK.
- Handshake rules:
  - A requester deasserts req, or presents a new transaction, on the edge after ack. req high in IDLE is always a new request.
  - Request fields must stay stable from req assertion until ack.
  - Changes to a non-granted requester's inputs have no effect.
- Starvation counter:
  - Increments on each EXE grant made while ifd_req=1.
  - Clears on IFD grant, or in IDLE when ifd_req=0.
  - Saturates at STARVE_LIMIT.
- mem_addr and mem_wdata hold their last values when mem_en=0. mem_we is 0 whenever mem_en=0.
- Reset mid-operation: the in-flight transaction is dropped. No ack is issued for it; the next cycle is IDLE with all outputs at reset values. Requesters must re-request.
- Addresses and data pass through unmodified; no width conversion, no wrap logic.

Optional Feature:
Macro PDP_MEM_ARB_RR_EN.
- Defined: selection on simultaneous requests is round-robin. The requester not granted most recently wins, and the last-grant flag resets to IFD, so EXE wins the first conflict. The starvation counter and STARVE_LIMIT are unused.
- Undefined: EXE priority with starvation counter, as specified under Behaviour.

Decomposition:
Shared package pdp_mem_arb_pkg holds:
- arb_state_e enum {IDLE, ISSUE, WAIT, ACK}
- arb_owner_e enum {OWN_NONE=0, OWN_IFD=1, OWN_EXE=2}
- constant STARVE_CNT_W=4

`ADDR_WIDTH and `DATA_WIDTH come from the existing global defines.

One sub-module, pdp_mem_arb_select: combinational winner select plus the registered starvation counter or round-robin flag, instantiated once.

Test Plan:
- IFD read alone, ifd_addr=0o0200, mem[0o0200]=0o7200, MEM_RD_LAT=1 -> mem_en=1 with mem_addr=0o0200 in cycle 1; ifd_ack=1 with ifd_rdata=0o7200 in cycle 3; owner=1 during cycles 1-3.
- EXE write exe_addr=0o0100, exe_wdata=0o1234 -> mem_en=mem_we=1 in cycle 1; exe_ack in cycle 2. A following EXE read of 0o0100 returns exe_rdata=0o1234.
- ifd_req and exe_req asserted in the same cycle -> EXE acked first; IFD granted in the IDLE after, with exactly one mem_en per transaction.
- exe_req held continuously, ifd_req held, STARVE_LIMIT=4 -> exactly 4 exe_ack pulses precede ifd_ack; the counter then clears and EXE resumes.
- reset asserted for one cycle during WAIT -> next cycle IDLE, owner=0, mem_en=0, no ack for the aborted read; a re-request completes normally.
- PDP_MEM_ARB_RR_EN defined, both requesters held continuously -> grants alternate EXE, IFD, EXE, IFD.

Source files
------------

// File: rtl/pdp_mem_arb_pkg.sv
// Shared types for the PDP-8 main-memory arbiter.
// Optional build macro PDP_MEM_ARB_RR_EN selects round-robin arbitration.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFD  = 2'd1,
    OWN_EXE  = 2'd2
  } arb_owner_e;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/pdp_mem_arb_select.sv
// Winner selection for the memory arbiter: EXE priority with a starvation
// counter, or round-robin when PDP_MEM_ARB_RR_EN is defined.
module pdp_mem_arb_select
  import pdp_mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       idle_i,
  input  logic       ifd_req_i,
  input  logic       exe_req_i,
  output arb_owner_e winner_o
);

`ifdef PDP_MEM_ARB_RR_EN
  logic last_ifd_q;

  always_comb begin
    winner_o = OWN_NONE;
    if (ifd_req_i && exe_req_i) winner_o = last_ifd_q ? OWN_EXE : OWN_IFD;
    else if (exe_req_i)         winner_o = OWN_EXE;
    else if (ifd_req_i)         winner_o = OWN_IFD;
  end

  // Flag starts at IFD so the first conflict goes to EXE.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_ifd_q <= 1'b1;
    end else if (idle_i && winner_o != OWN_NONE) begin
      last_ifd_q <= (winner_o == OWN_IFD);
    end
  end
`else
  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] starve_cnt_q;

  // NOTE: every output of an always_comb gets a default first, so no path leaves a latch.
  always_comb begin
    winner_o = OWN_NONE;
    if (ifd_req_i && exe_req_i) winner_o = (starve_cnt_q == LIMIT) ? OWN_IFD : OWN_EXE;
    else if (exe_req_i)         winner_o = OWN_EXE;
    else if (ifd_req_i)         winner_o = OWN_IFD;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      starve_cnt_q <= '0;
    end else if (idle_i) begin
      if (!ifd_req_i || winner_o == OWN_IFD) begin
        starve_cnt_q <= '0;
      end else if (winner_o == OWN_EXE && starve_cnt_q != LIMIT) begin
        starve_cnt_q <= starve_cnt_q + 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/pdp_mem_arbiter.sv
// Single-port PDP-8 memory arbiter between IFD (read-only) and EXE (read/write).
// Build macro PDP_MEM_ARB_RR_EN switches conflicts to round-robin selection.
module pdp_mem_arbiter
  import pdp_mem_arb_pkg::*;
#(
  parameter int MEM_RD_LAT   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ifd_req,
  input  logic [`ADDR_WIDTH-1:0] ifd_addr,
  output logic                   ifd_ack,
  output logic [`DATA_WIDTH-1:0] ifd_rdata,
  input  logic                   exe_req,
  input  logic                   exe_we,
  input  logic [`ADDR_WIDTH-1:0] exe_addr,
  input  logic [`DATA_WIDTH-1:0] exe_wdata,
  output logic                   exe_ack,
  output logic [`DATA_WIDTH-1:0] exe_rdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [`ADDR_WIDTH-1:0] mem_addr,
  output logic [`DATA_WIDTH-1:0] mem_wdata,
  input  logic [`DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]             owner
);

  localparam logic [2:0] WAIT_INIT = 3'(MEM_RD_LAT - 1);

  arb_state_e             state_q;
  arb_owner_e             owner_q;
  arb_owner_e             winner;
  logic [2:0]             wait_cnt_q;
  logic                   ifd_ack_q, exe_ack_q, mem_en_q, mem_we_q;
  logic [`ADDR_WIDTH-1:0] mem_addr_q;
  logic [`DATA_WIDTH-1:0] mem_wdata_q, ifd_rdata_q, exe_rdata_q;

  pdp_mem_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
    .clk_i     (clk),
    .reset_i   (reset),
    .idle_i    (state_q == IDLE),
    .ifd_req_i (ifd_req),
    .exe_req_i (exe_req),
    .winner_o  (winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      wait_cnt_q  <= '0;
      ifd_ack_q   <= 1'b0;
      exe_ack_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ifd_rdata_q <= '0;
      exe_rdata_q <= '0;
    end else begin
      // NOTE: strobes default low each cycle, so ack and mem_en are single-cycle pulses.
      ifd_ack_q <= 1'b0;
      exe_ack_q <= 1'b0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (winner != OWN_NONE) begin
            owner_q  <= winner;
            mem_en_q <= 1'b1;
            state_q  <= ISSUE;
            if (winner == OWN_EXE) begin
              mem_we_q    <= exe_we;
              mem_addr_q  <= exe_addr;
              mem_wdata_q <= exe_wdata;
            end else begin
              mem_addr_q  <= ifd_addr;
            end
          end
        end
        ISSUE: begin
          if (mem_we_q) begin
            state_q   <= ACK;
            exe_ack_q <= 1'b1;
          end else begin
            state_q    <= WAIT;
            wait_cnt_q <= WAIT_INIT;
          end
        end
        WAIT: begin
          if (wait_cnt_q == '0) begin
            state_q <= ACK;
            if (owner_q == OWN_IFD) begin
              ifd_rdata_q <= mem_rdata;
              ifd_ack_q   <= 1'b1;
            end else begin
              exe_rdata_q <= mem_rdata;
              exe_ack_q   <= 1'b1;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end
        ACK: begin
          state_q <= IDLE;
          owner_q <= OWN_NONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ifd_ack   = ifd_ack_q;
  assign ifd_rdata = ifd_rdata_q;
  assign exe_ack   = exe_ack_q;
  assign exe_rdata = exe_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_pdp_mem_arbiter.sv
// Directed self-checking bench for pdp_mem_arbiter with a 1-cycle memory model.
// Covers PDP_MEM_ARB_RR_EN when the macro is defined for the build.
module tb_pdp_mem_arbiter;

  logic                   clk;
  logic                   reset;
  logic                   ifd_req, exe_req, exe_we;
  logic [`ADDR_WIDTH-1:0] ifd_addr, exe_addr, mem_addr;
  logic [`DATA_WIDTH-1:0] exe_wdata, mem_wdata, mem_rdata, ifd_rdata, exe_rdata;
  logic                   ifd_ack, exe_ack, mem_en, mem_we;
  logic [1:0]             owner;

  logic                   mem_init;
  logic [`DATA_WIDTH-1:0] mem [0:(1<<`ADDR_WIDTH)-1];

  int checks;
  int errors;
  int ack_log[$];
  int cyc, men_cnt, last_ifd_cyc, last_exe_cyc;

  pdp_mem_arbiter #(.MEM_RD_LAT(1), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .ifd_req   (ifd_req),
    .ifd_addr  (ifd_addr),
    .ifd_ack   (ifd_ack),
    .ifd_rdata (ifd_rdata),
    .exe_req   (exe_req),
    .exe_we    (exe_we),
    .exe_addr  (exe_addr),
    .exe_wdata (exe_wdata),
    .exe_ack   (exe_ack),
    .exe_rdata (exe_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: read data appears one cycle after mem_en is sampled.
  always @(posedge clk) begin
    if (mem_init) begin
      mem[12'o0200] <= 12'o7200;
      mem_rdata     <= '0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Runs until n acks are seen or the budget expires, logging ack order.
  task automatic collect(input string tag, input int n_acks, input bit drop, input int budget);
    ack_log.delete();
    cyc = 0; men_cnt = 0; last_ifd_cyc = -1; last_exe_cyc = -1;
    while (ack_log.size() < n_acks && cyc < budget) begin
      step();
      cyc++;
      if (mem_en) men_cnt++;
      if (exe_ack) begin
        ack_log.push_back(2);
        last_exe_cyc = cyc;
        if (drop) exe_req = 1'b0;
      end
      if (ifd_ack) begin
        ack_log.push_back(1);
        last_ifd_cyc = cyc;
        if (drop) ifd_req = 1'b0;
      end
    end
    check({tag, "_ack_count"}, ack_log.size(), n_acks);
  endtask

  task automatic check_order(input string tag, input int exp_q[$]);
    foreach (exp_q[i]) begin
      check($sformatf("%s_order%0d", tag, i), (i < ack_log.size()) ? ack_log[i] : 0, exp_q[i]);
    end
  endtask

  initial begin
    int acks_seen;
    checks = 0; errors = 0;
    reset = 1'b1; mem_init = 1'b1;
    ifd_req = 1'b0; ifd_addr = '0;
    exe_req = 1'b0; exe_we = 1'b0; exe_addr = '0; exe_wdata = '0;
    repeat (2) step();

    check("rst_owner", owner, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_acks", {ifd_ack, exe_ack}, 0);
    check("rst_rdata", {ifd_rdata, exe_rdata}, 0);
    check("rst_mem_bus", {mem_we, mem_addr, mem_wdata}, 0);
    reset = 1'b0; mem_init = 1'b0;
    step();

    // IFD read alone
    ifd_req = 1'b1; ifd_addr = 12'o0200;
    step();
    check("ifd_c1_mem_en", mem_en, 1);
    check("ifd_c1_mem_we", mem_we, 0);
    check("ifd_c1_addr", mem_addr, 12'o0200);
    check("ifd_c1_owner", owner, 1);
    step();
    check("ifd_c2_owner", owner, 1);
    check("ifd_c2_mem_en", mem_en, 0);
    check("ifd_c2_ack", ifd_ack, 0);
    step();
    check("ifd_c3_ack", ifd_ack, 1);
    check("ifd_c3_rdata", ifd_rdata, 12'o7200);
    check("ifd_c3_owner", owner, 1);
    ifd_req = 1'b0;
    step();
    check("ifd_c4_owner", owner, 0);
    check("ifd_c4_ack", ifd_ack, 0);
    check("ifd_c4_rdata_hold", ifd_rdata, 12'o7200);

    // EXE write, non-granted IFD inputs wiggle
    exe_req = 1'b1; exe_we = 1'b1; exe_addr = 12'o0100; exe_wdata = 12'o1234;
    ifd_addr = 12'o0777;
    step();
    check("wr_c1_en_we", {mem_en, mem_we}, 2'b11);
    check("wr_c1_addr", mem_addr, 12'o0100);
    check("wr_c1_wdata", mem_wdata, 12'o1234);
    check("wr_c1_owner", owner, 2);
    step();
    check("wr_c2_ack", exe_ack, 1);
    check("wr_c2_en_we", {mem_en, mem_we}, 2'b00);
    exe_req = 1'b0;
    step();
    check("wr_c3_ack", exe_ack, 0);
    check("wr_c3_owner", owner, 0);
    check("wr_c3_addr_hold", mem_addr, 12'o0100);

    // EXE read-back
    exe_req = 1'b1; exe_we = 1'b0; exe_addr = 12'o0100;
    collect("rd", 1, 1'b1, 20);
    check("rd_ack_cycle", last_exe_cyc, 3);
    check("rd_rdata", exe_rdata, 12'o1234);
    check("rd_mem_en_cnt", men_cnt, 1);
    check("rd_ifd_rdata_untouched", ifd_rdata, 12'o7200);
    step();

    // Reset during WAIT drops the read
    ifd_req = 1'b1; ifd_addr = 12'o0200;
    step();
    step();
    reset = 1'b1; ifd_req = 1'b0;
    step();
    check("rstw_owner", owner, 0);
    check("rstw_mem_en", mem_en, 0);
    check("rstw_ack", ifd_ack, 0);
    check("rstw_rdata", {ifd_rdata, exe_rdata}, 0);
    reset = 1'b0;
    acks_seen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (ifd_ack || exe_ack || mem_en) acks_seen++;
    end
    check("rstw_no_activity", acks_seen, 0);
    ifd_req = 1'b1; ifd_addr = 12'o0200;
    collect("rerq", 1, 1'b1, 20);
    check("rerq_ack_cycle", last_ifd_cyc, 3);
    check("rerq_rdata", ifd_rdata, 12'o7200);
    step();

    // Simultaneous requests: EXE write first, then IFD read
    exe_req = 1'b1; exe_we = 1'b1; exe_addr = 12'o0101; exe_wdata = 12'o4321;
    ifd_req = 1'b1; ifd_addr = 12'o0200;
    collect("both", 2, 1'b1, 40);
    check_order("both", '{2, 1});
    check("both_exe_cycle", last_exe_cyc, 2);
    check("both_ifd_cycle", last_ifd_cyc, 6);
    check("both_mem_en_cnt", men_cnt, 2);
    check("both_ifd_rdata", ifd_rdata, 12'o7200);
    step();

    // Both held continuously
    exe_req = 1'b1; exe_we = 1'b1; exe_addr = 12'o0300; exe_wdata = 12'o0055;
    ifd_req = 1'b1; ifd_addr = 12'o0200;
`ifdef PDP_MEM_ARB_RR_EN
    collect("rr", 4, 1'b0, 100);
    check_order("rr", '{2, 1, 2, 1});
    check("rr_mem_en_cnt", men_cnt, 4);
`else
    collect("starve", 10, 1'b0, 200);
    check_order("starve", '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1});
    check("starve_mem_en_cnt", men_cnt, 10);
`endif
    exe_req = 1'b0; ifd_req = 1'b0;
    repeat (3) step();
    check("end_owner", owner, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
